// File: rtl/decode_dispatch.sv
// Decode/dispatch stage: instruction queue feeding the reservation stations and load/store buffer.
// Resolves operands from the register file, ROB and CDB, and issues one registered dispatch per cycle.
`ifndef DECODE_DISPATCH_OPS
`define DECODE_DISPATCH_OPS
`define OP_NONE  6'd0
`define OP_LUI   6'd1
`define OP_AUIPC 6'd2
`define OP_JAL   6'd3
`define OP_JALR  6'd4
`define OP_BEQ   6'd5
`define OP_BNE   6'd6
`define OP_BLT   6'd7
`define OP_BGE   6'd8
`define OP_BLTU  6'd9
`define OP_BGEU  6'd10
`define OP_LB    6'd11
`define OP_LH    6'd12
`define OP_LW    6'd13
`define OP_LBU   6'd14
`define OP_LHU   6'd15
`define OP_SB    6'd16
`define OP_SH    6'd17
`define OP_SW    6'd18
`define OP_ADDI  6'd19
`define OP_SLTI  6'd20
`define OP_SLTIU 6'd21
`define OP_XORI  6'd22
`define OP_ORI   6'd23
`define OP_ANDI  6'd24
`define OP_SLLI  6'd25
`define OP_SRLI  6'd26
`define OP_SRAI  6'd27
`define OP_ADD   6'd28
`define OP_SUB   6'd29
`define OP_SLL   6'd30
`define OP_SLT   6'd31
`define OP_SLTU  6'd32
`define OP_XOR   6'd33
`define OP_SRL   6'd34
`define OP_SRA   6'd35
`define OP_OR    6'd36
`define OP_AND   6'd37
`endif

module decode_dispatch #(
  parameter int IQ_DEPTH  = 8,
  parameter int ROB_TAG_W = 4,
  parameter int OP_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_clear,
  input  logic                 in_fetch_valid,
  input  logic [31:0]          in_fetch_instr,
  input  logic [31:0]          in_fetch_pc,
  output logic                 out_iq_full,
  output logic [4:0]           out_reg_tag1,
  output logic [4:0]           out_reg_tag2,
  input  logic [31:0]          in_reg_value1,
  input  logic [31:0]          in_reg_value2,
  input  logic [ROB_TAG_W-1:0] in_reg_robtag1,
  input  logic [ROB_TAG_W-1:0] in_reg_robtag2,
  input  logic                 in_reg_busy1,
  input  logic                 in_reg_busy2,
  output logic [ROB_TAG_W-1:0] out_rob_fetch_tag1,
  output logic [ROB_TAG_W-1:0] out_rob_fetch_tag2,
  input  logic [31:0]          in_rob_fetch_value1,
  input  logic [31:0]          in_rob_fetch_value2,
  input  logic                 in_rob_fetch_ready1,
  input  logic                 in_rob_fetch_ready2,
  input  logic                 in_cdb_valid,
  input  logic [ROB_TAG_W-1:0] in_cdb_tag,
  input  logic [31:0]          in_cdb_value,
  input  logic [ROB_TAG_W-1:0] in_rob_freetag,
  input  logic                 in_rob_full,
  input  logic                 in_rs_full,
  input  logic                 in_lsb_full,
  output logic                 out_valid,
  output logic                 out_to_lsb,
  output logic [OP_W-1:0]      out_op,
  output logic [ROB_TAG_W-1:0] out_rob_tag,
  output logic [4:0]           out_rd,
  output logic [31:0]          out_imm,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_value1,
  output logic [31:0]          out_value2,
  output logic [ROB_TAG_W-1:0] out_tag1,
  output logic [ROB_TAG_W-1:0] out_tag2
);

  localparam int PTR_W  = (IQ_DEPTH > 2) ? $clog2(IQ_DEPTH) : 1;
  localparam int OPND_W = 32 + ROB_TAG_W;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(IQ_DEPTH);

  logic [31:0]    iq_instr [IQ_DEPTH];
  logic [31:0]    iq_pc    [IQ_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic [31:0] h;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [5:0]  dec_op;
  logic [31:0] dec_imm;
  logic        dec_mem, use1, use2, writes_rd;
  logic [OPND_W-1:0] opnd1, opnd2;
  logic        has_head, is_illegal, target_full, dispatch, pop, push;

  assign h      = iq_instr[head];
  assign opcode = h[6:0];
  assign funct3 = h[14:12];
  assign funct7 = h[31:25];

  assign out_reg_tag1       = h[19:15];
  assign out_reg_tag2       = h[24:20];
  assign out_rob_fetch_tag1 = in_reg_robtag1;
  assign out_rob_fetch_tag2 = in_reg_robtag2;
  assign out_iq_full        = (count == CNT_FULL);

  assign imm_i  = {{20{h[31]}}, h[31:20]};
  assign imm_s  = {{20{h[31]}}, h[31:25], h[11:7]};
  assign imm_b  = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
  assign imm_u  = {h[31:12], 12'b0};
  assign imm_j  = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
  assign imm_sh = {26'b0, h[25:20]};

  // Any opcode/funct combination not mapped to an op leaves dec_op at OP_NONE (illegal).
  always_comb begin
    dec_op = `OP_NONE; dec_imm = '0; dec_mem = 1'b0;
    use1 = 1'b0; use2 = 1'b0; writes_rd = 1'b1;
    case (opcode)
      7'b0110111: begin dec_op = `OP_LUI;   dec_imm = imm_u; end
      7'b0010111: begin dec_op = `OP_AUIPC; dec_imm = imm_u; end
      7'b1101111: begin dec_op = `OP_JAL;   dec_imm = imm_j; end
      7'b1100111: begin
        if (funct3 == 3'b000) dec_op = `OP_JALR;
        dec_imm = imm_i; use1 = 1'b1;
      end
      7'b1100011: begin
        case (funct3)
          3'b000:  dec_op = `OP_BEQ;
          3'b001:  dec_op = `OP_BNE;
          3'b100:  dec_op = `OP_BLT;
          3'b101:  dec_op = `OP_BGE;
          3'b110:  dec_op = `OP_BLTU;
          3'b111:  dec_op = `OP_BGEU;
          default: dec_op = `OP_NONE;
        endcase
        dec_imm = imm_b; use1 = 1'b1; use2 = 1'b1; writes_rd = 1'b0;
      end
      7'b0000011: begin
        case (funct3)
          3'b000:  dec_op = `OP_LB;
          3'b001:  dec_op = `OP_LH;
          3'b010:  dec_op = `OP_LW;
          3'b100:  dec_op = `OP_LBU;
          3'b101:  dec_op = `OP_LHU;
          default: dec_op = `OP_NONE;
        endcase
        dec_imm = imm_i; dec_mem = 1'b1; use1 = 1'b1;
      end
      7'b0100011: begin
        case (funct3)
          3'b000:  dec_op = `OP_SB;
          3'b001:  dec_op = `OP_SH;
          3'b010:  dec_op = `OP_SW;
          default: dec_op = `OP_NONE;
        endcase
        dec_imm = imm_s; dec_mem = 1'b1; use1 = 1'b1; use2 = 1'b1; writes_rd = 1'b0;
      end
      7'b0010011: begin
        dec_imm = imm_i; use1 = 1'b1;
        case (funct3)
          3'b000:  dec_op = `OP_ADDI;
          3'b010:  dec_op = `OP_SLTI;
          3'b011:  dec_op = `OP_SLTIU;
          3'b100:  dec_op = `OP_XORI;
          3'b110:  dec_op = `OP_ORI;
          3'b111:  dec_op = `OP_ANDI;
          3'b001: begin
            dec_imm = imm_sh;
            if (funct7 == 7'b0000000) dec_op = `OP_SLLI;
          end
          default: begin
            dec_imm = imm_sh;
            if (funct7 == 7'b0000000)      dec_op = `OP_SRLI;
            else if (funct7 == 7'b0100000) dec_op = `OP_SRAI;
          end
        endcase
      end
      7'b0110011: begin
        use1 = 1'b1; use2 = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op = `OP_ADD;
            3'b001:  dec_op = `OP_SLL;
            3'b010:  dec_op = `OP_SLT;
            3'b011:  dec_op = `OP_SLTU;
            3'b100:  dec_op = `OP_XOR;
            3'b101:  dec_op = `OP_SRL;
            3'b110:  dec_op = `OP_OR;
            default: dec_op = `OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  dec_op = `OP_SUB;
            3'b101:  dec_op = `OP_SRA;
            default: dec_op = `OP_NONE;
          endcase
        end
      end
      default: dec_op = `OP_NONE;
    endcase
  end

  function automatic logic [OPND_W-1:0] resolve(
    input logic [4:0]           rs,
    input logic                 busy,
    input logic [31:0]          reg_val,
    input logic [ROB_TAG_W-1:0] robtag,
    input logic                 rob_ready,
    input logic [31:0]          rob_val,
    input logic                 cdb_valid,
    input logic [ROB_TAG_W-1:0] cdb_tag,
    input logic [31:0]          cdb_val
  );
    if (rs == 5'd0) return '0;
    if (!busy) return {reg_val, {ROB_TAG_W{1'b0}}};
    if (rob_ready) return {rob_val, {ROB_TAG_W{1'b0}}};
    if (cdb_valid && cdb_tag == robtag) return {cdb_val, {ROB_TAG_W{1'b0}}};
    return {32'd0, robtag};
  endfunction

  assign opnd1 = use1 ? resolve(h[19:15], in_reg_busy1, in_reg_value1, in_reg_robtag1,
                                in_rob_fetch_ready1, in_rob_fetch_value1,
                                in_cdb_valid, in_cdb_tag, in_cdb_value) : '0;
  assign opnd2 = use2 ? resolve(h[24:20], in_reg_busy2, in_reg_value2, in_reg_robtag2,
                                in_rob_fetch_ready2, in_rob_fetch_value2,
                                in_cdb_valid, in_cdb_tag, in_cdb_value) : '0;

  // Illegal heads drain regardless of back-end pressure so they cannot block the queue.
  assign has_head    = (count != '0);
  assign is_illegal  = (dec_op == `OP_NONE);
  assign target_full = dec_mem ? in_lsb_full : in_rs_full;
  assign dispatch    = has_head && !is_illegal && !in_rob_full && !target_full;
  assign pop         = dispatch || (has_head && is_illegal);
  assign push        = in_fetch_valid && !out_iq_full;

  always_ff @(posedge clk) begin
    if (!rst && rdy && !in_clear && push) begin
      iq_instr[tail] <= in_fetch_instr;
      iq_pc[tail]    <= in_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0; tail <= '0; count <= '0;
      out_valid <= 1'b0; out_to_lsb <= 1'b0; out_op <= '0; out_rob_tag <= '0;
      out_rd <= '0; out_imm <= '0; out_pc <= '0;
      out_value1 <= '0; out_value2 <= '0; out_tag1 <= '0; out_tag2 <= '0;
    end else if (rdy) begin
      if (in_clear) begin
        head <= tail; count <= '0; out_valid <= 1'b0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        out_valid <= dispatch;
        if (dispatch) begin
          out_to_lsb  <= dec_mem;
          out_op      <= OP_W'(dec_op);
          out_rob_tag <= in_rob_freetag;
          out_rd      <= writes_rd ? h[11:7] : 5'd0;
          out_imm     <= dec_imm;
          out_pc      <= iq_pc[head];
          {out_value1, out_tag1} <= opnd1;
          {out_value2, out_tag2} <= opnd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_dispatch.sv
// Self-checking bench for decode_dispatch: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_decode_dispatch;

  localparam int DEPTH = 8;

  logic        clk, rst, rdy, in_clear;
  logic        in_fetch_valid;
  logic [31:0] in_fetch_instr, in_fetch_pc;
  logic        out_iq_full;
  logic [4:0]  out_reg_tag1, out_reg_tag2;
  logic [31:0] in_reg_value1, in_reg_value2;
  logic [3:0]  in_reg_robtag1, in_reg_robtag2;
  logic        in_reg_busy1, in_reg_busy2;
  logic [3:0]  out_rob_fetch_tag1, out_rob_fetch_tag2;
  logic [31:0] in_rob_fetch_value1, in_rob_fetch_value2;
  logic        in_rob_fetch_ready1, in_rob_fetch_ready2;
  logic        in_cdb_valid;
  logic [3:0]  in_cdb_tag;
  logic [31:0] in_cdb_value;
  logic [3:0]  in_rob_freetag;
  logic        in_rob_full, in_rs_full, in_lsb_full;
  logic        out_valid, out_to_lsb;
  logic [5:0]  out_op;
  logic [3:0]  out_rob_tag;
  logic [4:0]  out_rd;
  logic [31:0] out_imm, out_pc, out_value1, out_value2;
  logic [3:0]  out_tag1, out_tag2;

  decode_dispatch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_clear(in_clear),
    .in_fetch_valid(in_fetch_valid), .in_fetch_instr(in_fetch_instr), .in_fetch_pc(in_fetch_pc),
    .out_iq_full(out_iq_full), .out_reg_tag1(out_reg_tag1), .out_reg_tag2(out_reg_tag2),
    .in_reg_value1(in_reg_value1), .in_reg_value2(in_reg_value2),
    .in_reg_robtag1(in_reg_robtag1), .in_reg_robtag2(in_reg_robtag2),
    .in_reg_busy1(in_reg_busy1), .in_reg_busy2(in_reg_busy2),
    .out_rob_fetch_tag1(out_rob_fetch_tag1), .out_rob_fetch_tag2(out_rob_fetch_tag2),
    .in_rob_fetch_value1(in_rob_fetch_value1), .in_rob_fetch_value2(in_rob_fetch_value2),
    .in_rob_fetch_ready1(in_rob_fetch_ready1), .in_rob_fetch_ready2(in_rob_fetch_ready2),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_rob_freetag(in_rob_freetag), .in_rob_full(in_rob_full),
    .in_rs_full(in_rs_full), .in_lsb_full(in_lsb_full),
    .out_valid(out_valid), .out_to_lsb(out_to_lsb), .out_op(out_op), .out_rob_tag(out_rob_tag),
    .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
    .out_value1(out_value1), .out_value2(out_value2), .out_tag1(out_tag1), .out_tag2(out_tag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lsb;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use1;
    logic        use2;
  } dec_t;

  typedef struct packed {
    logic [31:0] v;
    logic [3:0]  t;
  } opnd_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] pc_ctr = 32'h1000;

  logic [63:0] q[$];
  logic        model_live = 1'b0;
  logic        exp_zero = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_lsb;
  logic [5:0]  exp_op;
  logic [3:0]  exp_robtag;
  logic [4:0]  exp_rd;
  logic [31:0] exp_imm, exp_pc;
  opnd_t       exp_o1, exp_o2;

  // Op numbering follows the listed RV32I order: LUI=1 ... AND=37, 0 = not a legal instruction.
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic signed [11:0] ii, si;
    logic signed [12:0] bi;
    logic signed [20:0] ji;
    logic [2:0] f3;
    logic [6:0] f7;
    ii = i[31:20];
    si = {i[31:25], i[11:7]};
    bi = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    ji = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    f3 = i[14:12];
    f7 = i[31:25];
    d = '0;
    d.rd = i[11:7];
    case (i[6:0])
      7'h37: begin d.op = 6'd1; d.imm = {i[31:12], 12'h000}; end
      7'h17: begin d.op = 6'd2; d.imm = {i[31:12], 12'h000}; end
      7'h6F: begin d.op = 6'd3; d.imm = 32'(ji); end
      7'h67: begin d.op = (f3 == 3'd0) ? 6'd4 : 6'd0; d.imm = 32'(ii); d.use1 = 1'b1; end
      7'h63: begin
        case (f3)
          3'd0: d.op = 6'd5;  3'd1: d.op = 6'd6;  3'd4: d.op = 6'd7;
          3'd5: d.op = 6'd8;  3'd6: d.op = 6'd9;  3'd7: d.op = 6'd10;
          default: d.op = 6'd0;
        endcase
        d.rd = 5'd0; d.imm = 32'(bi); d.use1 = 1'b1; d.use2 = 1'b1;
      end
      7'h03: begin
        case (f3)
          3'd0: d.op = 6'd11; 3'd1: d.op = 6'd12; 3'd2: d.op = 6'd13;
          3'd4: d.op = 6'd14; 3'd5: d.op = 6'd15;
          default: d.op = 6'd0;
        endcase
        d.lsb = 1'b1; d.imm = 32'(ii); d.use1 = 1'b1;
      end
      7'h23: begin
        d.op = (f3 < 3'd3) ? 6'(16 + f3) : 6'd0;
        d.lsb = 1'b1; d.rd = 5'd0; d.imm = 32'(si); d.use1 = 1'b1; d.use2 = 1'b1;
      end
      7'h13: begin
        case (f3)
          3'd0: d.op = 6'd19; 3'd2: d.op = 6'd20; 3'd3: d.op = 6'd21;
          3'd4: d.op = 6'd22; 3'd6: d.op = 6'd23; 3'd7: d.op = 6'd24;
          3'd1: d.op = (f7 == 7'h00) ? 6'd25 : 6'd0;
          default: d.op = (f7 == 7'h00) ? 6'd26 : ((f7 == 7'h20) ? 6'd27 : 6'd0);
        endcase
        d.imm = (f3 == 3'd1 || f3 == 3'd5) ? {26'd0, i[25:20]} : 32'(ii);
        d.use1 = 1'b1;
      end
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: d.op = 6'd28; 3'd1: d.op = 6'd30; 3'd2: d.op = 6'd31; 3'd3: d.op = 6'd32;
            3'd4: d.op = 6'd33; 3'd5: d.op = 6'd34; 3'd6: d.op = 6'd36; default: d.op = 6'd37;
          endcase
        end else if (f7 == 7'h20) begin
          d.op = (f3 == 3'd0) ? 6'd29 : ((f3 == 3'd5) ? 6'd35 : 6'd0);
        end
        d.use1 = 1'b1; d.use2 = 1'b1;
      end
      default: d.op = 6'd0;
    endcase
    return d;
  endfunction

  function automatic opnd_t resolve(input logic used, input logic [4:0] rs, input logic busy,
                                    input logic [31:0] rv, input logic [3:0] rt,
                                    input logic rob_rdy, input logic [31:0] robv);
    opnd_t o;
    o = '0;
    if (!used || rs == 5'd0) return o;
    if (!busy)                                    o.v = rv;
    else if (rob_rdy)                             o.v = robv;
    else if (in_cdb_valid && in_cdb_tag == rt)    o.v = in_cdb_value;
    else                                          o.t = rt;
    return o;
  endfunction

  // Reference model: advances on every rising edge from the inputs the bench is holding.
  dec_t        md;
  logic [63:0] me;
  logic        mgo, mpop, mfull;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      model_live = 1'b1; exp_zero = 1'b1; exp_valid = 1'b0;
      exp_lsb = 1'b0; exp_op = '0; exp_robtag = '0; exp_rd = '0;
      exp_imm = '0; exp_pc = '0; exp_o1 = '0; exp_o2 = '0;
    end else if (rdy) begin
      exp_zero = 1'b0;
      if (in_clear) begin
        q.delete();
        exp_valid = 1'b0;
      end else begin
        mfull = (q.size() == DEPTH);
        mgo = 1'b0; mpop = 1'b0;
        if (q.size() > 0) begin
          me = q[0];
          md = decode(me[63:32]);
          if (md.op == 6'd0) mpop = 1'b1;
          else if (!in_rob_full && !(md.lsb ? in_lsb_full : in_rs_full)) begin
            mgo = 1'b1; mpop = 1'b1;
          end
        end
        exp_valid = mgo;
        if (mgo) begin
          exp_lsb = md.lsb; exp_op = md.op; exp_rd = md.rd; exp_imm = md.imm;
          exp_pc = me[31:0]; exp_robtag = in_rob_freetag;
          exp_o1 = resolve(md.use1, me[51:47], in_reg_busy1, in_reg_value1, in_reg_robtag1,
                           in_rob_fetch_ready1, in_rob_fetch_value1);
          exp_o2 = resolve(md.use2, me[56:52], in_reg_busy2, in_reg_value2, in_reg_robtag2,
                           in_rob_fetch_ready2, in_rob_fetch_value2);
        end
        if (mpop) void'(q.pop_front());
        if (in_fetch_valid && !mfull) q.push_back({in_fetch_instr, in_fetch_pc});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (model_live) begin
      checkOutput("valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("iq_full", 32'(out_iq_full), 32'(q.size() == DEPTH));
      checkOutput("rob_fetch_tag1", 32'(out_rob_fetch_tag1), 32'(in_reg_robtag1));
      checkOutput("rob_fetch_tag2", 32'(out_rob_fetch_tag2), 32'(in_reg_robtag2));
      if (q.size() > 0) begin
        checkOutput("reg_tag1", 32'(out_reg_tag1), 32'(q[0][51:47]));
        checkOutput("reg_tag2", 32'(out_reg_tag2), 32'(q[0][56:52]));
      end
      if (exp_valid || exp_zero) begin
        checkOutput("to_lsb", 32'(out_to_lsb), 32'(exp_lsb));
        checkOutput("op", 32'(out_op), 32'(exp_op));
        checkOutput("rob_tag", 32'(out_rob_tag), 32'(exp_robtag));
        checkOutput("rd", 32'(out_rd), 32'(exp_rd));
        checkOutput("imm", out_imm, exp_imm);
        checkOutput("pc", out_pc, exp_pc);
        checkOutput("value1", out_value1, exp_o1.v);
        checkOutput("tag1", 32'(out_tag1), 32'(exp_o1.t));
        checkOutput("value2", out_value2, exp_o2.v);
        checkOutput("tag2", 32'(out_tag2), 32'(exp_o2.t));
      end
    end
  end

  task automatic applyStimulus(input logic fv, input logic [31:0] instr);
    in_fetch_valid = fv;
    in_fetch_instr = instr;
    in_fetch_pc    = pc_ctr;
    pc_ctr         = pc_ctr + 32'd4;
    in_rob_freetag = in_rob_freetag + 4'd1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; in_clear = 1'b0;
    in_fetch_valid = 1'b0; in_fetch_instr = '0; in_fetch_pc = '0;
    in_reg_value1 = '0; in_reg_value2 = '0; in_reg_robtag1 = '0; in_reg_robtag2 = '0;
    in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0;
    in_rob_fetch_value1 = 32'hDEAD0001; in_rob_fetch_value2 = 32'hDEAD0002;
    in_rob_fetch_ready1 = 1'b0; in_rob_fetch_ready2 = 1'b0;
    in_cdb_valid = 1'b0; in_cdb_tag = '0; in_cdb_value = '0;
    in_rob_freetag = '0; in_rob_full = 1'b0; in_rs_full = 1'b0; in_lsb_full = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h0);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_full", 32'(out_iq_full), 32'd0);
    checkOutput("reset_imm", out_imm, 32'd0);
    rst = 1'b0;

    // ADDI x1,x2,-1 with x2 ready
    in_reg_busy1 = 1'b0; in_reg_value1 = 32'd5;
    applyStimulus(1'b1, 32'hFFF10093);
    applyStimulus(1'b0, 32'h0);
    checkOutput("addi_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_lsb", 32'(out_to_lsb), 32'd0);
    checkOutput("addi_op", 32'(out_op), 32'd19);
    checkOutput("addi_rd", 32'(out_rd), 32'd1);
    checkOutput("addi_imm", out_imm, 32'hFFFFFFFF);
    checkOutput("addi_value1", out_value1, 32'd5);
    checkOutput("addi_tag1", 32'(out_tag1), 32'd0);

    // Fill the queue while the RS is full, then drop a ninth fetch
    in_rs_full = 1'b1;
    for (int k = 1; k <= 9; k++) applyStimulus(1'b1, (32'(k) << 20) | 32'h00000093);
    checkOutput("fill_full", 32'(out_iq_full), 32'd1);
    checkOutput("fill_no_dispatch", 32'(out_valid), 32'd0);
    in_rs_full = 1'b0;
    applyStimulus(1'b1, (32'd10 << 20) | 32'h00000093);
    checkOutput("release_valid", 32'(out_valid), 32'd1);
    checkOutput("release_imm", out_imm, 32'd1);
    in_rs_full = 1'b1;
    applyStimulus(1'b1, (32'd10 << 20) | 32'h00000093);
    checkOutput("refill_valid", 32'(out_valid), 32'd0);
    checkOutput("refill_full", 32'(out_iq_full), 32'd1);
    in_rs_full = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'h0);
    checkOutput("drain_last_imm", out_imm, 32'd10);
    applyStimulus(1'b0, 32'h0);
    checkOutput("drain_empty", 32'(out_valid), 32'd0);

    // SW x3,8(x4): base forwarded from the CDB in the dispatch cycle
    in_reg_busy1 = 1'b1; in_reg_robtag1 = 4'd3; in_rob_fetch_ready1 = 1'b0;
    in_reg_busy2 = 1'b0; in_reg_value2 = 32'h33;
    in_cdb_valid = 1'b1; in_cdb_tag = 4'd3; in_cdb_value = 32'h100;
    applyStimulus(1'b1, 32'h00322423);
    applyStimulus(1'b0, 32'h0);
    checkOutput("sw_lsb", 32'(out_to_lsb), 32'd1);
    checkOutput("sw_op", 32'(out_op), 32'd18);
    checkOutput("sw_value1", out_value1, 32'h100);
    checkOutput("sw_tag1", 32'(out_tag1), 32'd0);
    checkOutput("sw_imm", out_imm, 32'd8);
    checkOutput("sw_rd", 32'(out_rd), 32'd0);
    checkOutput("sw_value2", out_value2, 32'h33);
    in_cdb_valid = 1'b0;

    // ADD x5,x6,x7 with x7 pending, then ADD x5,x0,x7
    in_reg_busy1 = 1'b0; in_reg_value1 = 32'h66;
    in_reg_busy2 = 1'b1; in_reg_robtag2 = 4'd2; in_rob_fetch_ready2 = 1'b0;
    applyStimulus(1'b1, 32'h007302B3);
    applyStimulus(1'b0, 32'h0);
    checkOutput("add_op", 32'(out_op), 32'd28);
    checkOutput("add_value1", out_value1, 32'h66);
    checkOutput("add_tag2", 32'(out_tag2), 32'd2);
    checkOutput("add_value2", out_value2, 32'd0);
    in_reg_busy1 = 1'b1; in_reg_robtag1 = 4'd5;
    applyStimulus(1'b1, 32'h007002B3);
    applyStimulus(1'b0, 32'h0);
    checkOutput("add_x0_value1", out_value1, 32'd0);
    checkOutput("add_x0_tag1", 32'(out_tag1), 32'd0);
    in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0;

    // Flush with three queued entries and a concurrent fetch
    in_rs_full = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h00100093);
    in_clear = 1'b1;
    applyStimulus(1'b1, 32'h00200093);
    checkOutput("clear_valid", 32'(out_valid), 32'd0);
    checkOutput("clear_full", 32'(out_iq_full), 32'd0);
    in_clear = 1'b0; in_rs_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0);
      checkOutput("post_clear_idle", 32'(out_valid), 32'd0);
    end

    // Illegal head drains even with the ROB full; LUI follows
    in_rob_full = 1'b1;
    applyStimulus(1'b1, 32'h0000007F);
    applyStimulus(1'b1, 32'h123450B7);
    checkOutput("illegal_silent", 32'(out_valid), 32'd0);
    in_rob_full = 1'b0;
    applyStimulus(1'b0, 32'h0);
    checkOutput("lui_valid", 32'(out_valid), 32'd1);
    checkOutput("lui_op", 32'(out_op), 32'd1);
    checkOutput("lui_imm", out_imm, 32'h12345000);

    applyStimulus(1'b1, 32'h008000EF);
    applyStimulus(1'b0, 32'h0);
    checkOutput("jal_pos_imm", out_imm, 32'd8);
    applyStimulus(1'b1, 32'hFFDFF06F);
    applyStimulus(1'b0, 32'h0);
    checkOutput("jal_neg_imm", out_imm, 32'hFFFFFFFC);
    in_reg_value1 = 32'h11; in_reg_value2 = 32'h22;
    applyStimulus(1'b1, 32'h00208863);
    applyStimulus(1'b0, 32'h0);
    checkOutput("beq_pos_imm", out_imm, 32'd16);
    applyStimulus(1'b1, 32'hFE000FE3);
    applyStimulus(1'b0, 32'h0);
    checkOutput("beq_neg_imm", out_imm, 32'hFFFFFFFE);
    checkOutput("beq_op", 32'(out_op), 32'd5);

    // rdy low freezes everything including the last dispatch pulse
    applyStimulus(1'b1, 32'h00500093);
    applyStimulus(1'b0, 32'h0);
    rdy = 1'b0;
    applyStimulus(1'b1, 32'h00600093);
    applyStimulus(1'b1, 32'h00600093);
    checkOutput("rdy_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("rdy_hold_imm", out_imm, 32'd5);
    rdy = 1'b1;
    applyStimulus(1'b0, 32'h0);
    checkOutput("rdy_no_enqueue", 32'(out_valid), 32'd0);

    // Reset mid-operation discards the queue
    in_rs_full = 1'b1;
    applyStimulus(1'b1, 32'h00700093);
    applyStimulus(1'b1, 32'h00800093);
    rst = 1'b1; in_rs_full = 1'b0;
    applyStimulus(1'b1, 32'h00900093);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_imm", out_imm, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("midrst_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
